// File: rtl/anc_fir_sequencer.sv
// Sequences one ANC sample pair through an external FIR/LMS engine and derives the
// next weight-adjust term from the returned error sample.
module anc_fir_sequencer #(
    parameter int unsigned TAPS        = 128,
    parameter int unsigned TIMEOUT_CYC = TAPS + 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        adapt_en,
    input  logic [15:0] mu,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ref_sample,
    input  logic [15:0] pri_sample,
    output logic [15:0] fir_x_in,
    output logic [15:0] fir_a_in,
    output logic [15:0] fir_weight_adjust,
    output logic        fir_go,
    input  logic [15:0] fir_out_sample,
    input  logic        fir_done,
    output logic        out_valid,
    output logic [15:0] out_sample,
    output logic        busy,
    output logic        err_timeout,
    input  logic        clr_err,
    output logic [15:0] sample_cnt
);

    localparam int unsigned DW      = 16;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYC + 1);
    // err_timeout must rise TIMEOUT_CYC cycles after fir_go rises; the counter starts
    // one cycle after fir_go and the flag lands one edge after the compare.
    localparam int unsigned TO_LAST = TIMEOUT_CYC - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_UPDATE
    } state_t;

    state_t           r_state;
    logic             r_buf_full;
    logic [DW-1:0]    r_buf_ref;
    logic [DW-1:0]    r_buf_pri;
    logic [DW-1:0]    r_x;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_wadj_out;
    logic             r_go;
    logic [DW-1:0]    r_wadj;
    logic [DW-1:0]    r_e;
    logic             r_out_valid;
    logic             r_err;
    logic [DW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_tcnt;

    logic             w_hs;
    logic             w_to_hit;
    logic [DW-1:0]    w_wadj_nxt;

    // Q1.15 x Q1.15 -> Q1.15; only -1 * -1 can overflow.
    function automatic logic [DW-1:0] sat_q15(input logic signed [31:0] p);
        return (p[31] != p[30]) ? 16'h7FFF : p[30:15];
    endfunction

    assign w_hs       = in_valid & ~r_buf_full;
    assign w_to_hit   = (r_tcnt == CNT_W'(TO_LAST));
    assign w_wadj_nxt = adapt_en ? sat_q15(32'($signed(r_e)) * 32'($signed(mu))) : '0;

    assign in_ready          = ~r_buf_full;
    assign busy              = (r_state != S_IDLE);
    assign fir_x_in          = r_x;
    assign fir_a_in          = r_a;
    assign fir_weight_adjust = r_wadj_out;
    assign fir_go            = r_go;
    assign out_valid         = r_out_valid;
    assign out_sample        = r_e;
    assign err_timeout       = r_err;
    assign sample_cnt        = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_buf_full  <= 1'b0;
            r_buf_ref   <= '0;
            r_buf_pri   <= '0;
            r_x         <= '0;
            r_a         <= '0;
            r_wadj_out  <= '0;
            r_go        <= 1'b0;
            r_wadj      <= '0;
            r_e         <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_tcnt      <= '0;
        end else begin
            r_go        <= 1'b0;
            r_out_valid <= 1'b0;
            if (w_hs) begin
                r_buf_full <= 1'b1;
                r_buf_ref  <= ref_sample;
                r_buf_pri  <= pri_sample;
            end
            // A timeout set later in this block overrides the clear.
            if (clr_err) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (en && r_buf_full) begin
                        r_x        <= r_buf_ref;
                        r_a        <= r_buf_pri;
                        r_wadj_out <= r_wadj;
                        r_go       <= 1'b1;
                        r_state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_buf_full <= 1'b0;
                    r_tcnt     <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (fir_done) begin
                        r_e         <= fir_out_sample;
                        r_out_valid <= 1'b1;
                        r_state     <= S_UPDATE;
                    end else if (w_to_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_wadj  <= w_wadj_nxt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
